note_lane: RTL and testbench

- Parametrised successor to the single falling-note generator: one guitar lane holding up to NUM_SLOTS independent falling notes.
- Notes spawn on request with a per-note height and fall SPEED pixels per gameclk tick.
- A strum is judged against a hit window; notes that leave the screen are reported as misses.
- Sits between the chart/spawn sequencer and the VGA renderer/scorer; one instance per lane.

---
 rtl/note_lane.sv | 145 ++++++++++++++
 tb/tb_note_lane.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane.sv
// One guitar lane holding up to NUM_SLOTS falling notes with strum judging and miss detection.
// Optional hit/miss statistics counters are enabled by defining NOTE_LANE_STATS_EN.
module note_lane #(
  parameter int H_MIDDLE  = 320,
  parameter int WIDTH     = 40,
  parameter int NUM_SLOTS = 4,
  parameter int SPEED     = 1,
  parameter int SCREEN_H  = 480,
  parameter int HIT_Y     = 440,
  parameter int HIT_WIN   = 16
) (
  input  logic                     gameclk,
  input  logic                     in_reset_n,
  input  logic                     in_spawn,
  input  logic [8:0]               in_height,
  input  logic                     in_strum,
  output logic [9:0]               o_xlow,
  output logic [9:0]               o_xhigh,
  output logic [NUM_SLOTS-1:0]     o_active,
  output logic [10*NUM_SLOTS-1:0]  o_yhigh,
  output logic [10*NUM_SLOTS-1:0]  o_ylow,
  output logic                     o_hit,
  output logic                     o_ghost,
  output logic                     o_miss,
  output logic                     o_overflow,
  output logic [15:0]              o_hit_count,
  output logic [15:0]              o_miss_count
);

  localparam logic [10:0] HIT_LO    = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] HIT_HI    = 11'(HIT_Y + HIT_WIN);
  localparam logic [10:0] MISS_BASE = 11'(SCREEN_H - 1);
  localparam logic [9:0]  STEP      = 10'(SPEED);

  logic [NUM_SLOTS-1:0] active;
  logic [9:0]           yhigh  [NUM_SLOTS];
  logic [8:0]           height [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] hit_sel;
  logic [NUM_SLOTS-1:0] past;
  logic [NUM_SLOTS-1:0] miss_sel;
  logic [NUM_SLOTS-1:0] free_sel;
  logic                 found;
  logic                 free_found;
  logic [9:0]           best_y;
  logic [3:0]           miss_num;

  assign o_xlow   = 10'(H_MIDDLE - WIDTH);
  assign o_xhigh  = 10'(H_MIDDLE + WIDTH);
  assign o_active = active;

  // Everything below is decided from start-of-cycle state only.
  // NOTE: combinational logic uses blocking '=' with a default for every output first, so no latch is inferred.
  always_comb begin
    hit_sel    = '0;
    past       = '0;
    miss_sel   = '0;
    free_sel   = '0;
    found      = 1'b0;
    free_found = 1'b0;
    best_y     = '0;
    miss_num   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      past[i] = active[i] && ({1'b0, yhigh[i]} > (MISS_BASE + {2'b00, height[i]}));
      // Strict '>' keeps the lowest index on equal heights.
      if (in_strum && active[i] &&
          ({1'b0, yhigh[i]} >= HIT_LO) && ({1'b0, yhigh[i]} <= HIT_HI) &&
          (!found || (yhigh[i] > best_y))) begin
        found      = 1'b1;
        best_y     = yhigh[i];
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
      if (!active[i] && !free_found) begin
        free_found  = 1'b1;
        free_sel[i] = 1'b1;
      end
    end
    miss_sel = past & ~hit_sel;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (miss_sel[i]) miss_num = miss_num + 4'd1;
    end
  end

  always_comb begin
    o_yhigh = '0;
    o_ylow  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      o_yhigh[10*i +: 10] = yhigh[i];
      o_ylow[10*i +: 10]  = (yhigh[i] >= {1'b0, height[i]}) ? (yhigh[i] - {1'b0, height[i]}) : 10'd0;
    end
  end

  // NOTE: the per-slot arrays are a handful of flops, not a RAM, so they take the async reset like all other state.
  always_ff @(posedge gameclk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      active     <= '0;
      o_hit      <= 1'b0;
      o_ghost    <= 1'b0;
      o_miss     <= 1'b0;
      o_overflow <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        yhigh[i]  <= '0;
        height[i] <= 9'd1;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_sel[i] || miss_sel[i]) begin
          active[i] <= 1'b0;
        end else if (free_sel[i] && in_spawn) begin
          active[i] <= 1'b1;
          yhigh[i]  <= '0;
          height[i] <= (in_height == 9'd0) ? 9'd1 : in_height;
        end else if (active[i]) begin
          yhigh[i] <= yhigh[i] + STEP;
        end
      end
      o_hit      <= |hit_sel;
      o_ghost    <= in_strum && !found;
      o_miss     <= |miss_sel;
      o_overflow <= in_spawn && !free_found;
    end
  end

`ifdef NOTE_LANE_STATS_EN
  logic [16:0] miss_sum;
  assign miss_sum = {1'b0, o_miss_count} + 17'(miss_num);

  always_ff @(posedge gameclk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      if (found && (o_hit_count != 16'hFFFF)) o_hit_count <= o_hit_count + 16'd1;
      o_miss_count <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`else
  logic unused_miss_num;
  assign unused_miss_num = ^miss_num;
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_note_lane.sv
// Directed bench for note_lane: default lane plus a 2-slot SPEED=7 lane for the simultaneous-miss case.
module tb_note_lane;

  logic        gameclk    = 1'b0;
  logic        in_reset_n = 1'b0;
  logic        in_spawn   = 1'b0;
  logic [8:0]  in_height  = '0;
  logic        in_strum   = 1'b0;
  logic [9:0]  o_xlow, o_xhigh;
  logic [3:0]  o_active;
  logic [39:0] o_yhigh, o_ylow;
  logic        o_hit, o_ghost, o_miss, o_overflow;
  logic [15:0] o_hit_count, o_miss_count;

  logic        spawn2  = 1'b0;
  logic [8:0]  height2 = '0;
  logic        strum2  = 1'b0;
  logic [9:0]  xlow2, xhigh2;
  logic [1:0]  active2;
  logic [19:0] yhigh2, ylow2;
  logic        hit2, ghost2, miss2, ovf2;
  logic [15:0] hc2, mc2;

  int checks = 0;
  int errors = 0;
  bit saw_hit, saw_ghost, saw_miss, saw_ovf;

`ifdef NOTE_LANE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  note_lane u_dut (
    .gameclk(gameclk), .in_reset_n(in_reset_n), .in_spawn(in_spawn), .in_height(in_height),
    .in_strum(in_strum), .o_xlow(o_xlow), .o_xhigh(o_xhigh), .o_active(o_active),
    .o_yhigh(o_yhigh), .o_ylow(o_ylow), .o_hit(o_hit), .o_ghost(o_ghost), .o_miss(o_miss),
    .o_overflow(o_overflow), .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  note_lane #(.NUM_SLOTS(2), .SPEED(7)) u_dut2 (
    .gameclk(gameclk), .in_reset_n(in_reset_n), .in_spawn(spawn2), .in_height(height2),
    .in_strum(strum2), .o_xlow(xlow2), .o_xhigh(xhigh2), .o_active(active2),
    .o_yhigh(yhigh2), .o_ylow(ylow2), .o_hit(hit2), .o_ghost(ghost2), .o_miss(miss2),
    .o_overflow(ovf2), .o_hit_count(hc2), .o_miss_count(mc2)
  );

  always #5 gameclk = ~gameclk;

  function automatic logic [9:0] yh(input int i);
    return o_yhigh[10*i +: 10];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge gameclk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      saw_hit   |= o_hit;
      saw_ghost |= o_ghost;
      saw_miss  |= o_miss;
      saw_ovf   |= o_overflow;
    end
  endtask

  task automatic clr_flags();
    saw_hit = 0; saw_ghost = 0; saw_miss = 0; saw_ovf = 0;
  endtask

  task automatic spawn_tick(input logic [8:0] h);
    in_height = h;
    in_spawn  = 1'b1;
    tick();
    in_spawn  = 1'b0;
  endtask

  task automatic strum_tick();
    in_strum = 1'b1;
    tick();
    in_strum = 1'b0;
  endtask

  task automatic do_reset();
    in_reset_n = 1'b0;
    tick();
    tick();
    in_reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_active", o_active, 0);
    check("rst_yhigh", o_yhigh, 0);
    check("rst_ylow", o_ylow, 0);
    check("rst_pulses", {o_hit, o_ghost, o_miss, o_overflow}, 0);
    check("rst_counts", {o_hit_count, o_miss_count}, 0);
    check("xlow", o_xlow, 280);
    check("xhigh", o_xhigh, 360);
    tick();
    in_reset_n = 1'b1;

    // Single note, height 100, falls off the bottom
    spawn_tick(9'd100);
    check("t1_active", o_active, 4'b0001);
    check("t1_y0", yh(0), 0);
    clr_flags();
    run(99);
    check("t1_y99", yh(0), 99);
    check("t1_ylow99", o_ylow[9:0], 0);
    run(2);
    check("t1_ylow101", o_ylow[9:0], 1);
    run(479);
    check("t1_y580", yh(0), 580);
    check("t1_active580", o_active, 4'b0001);
    check("t1_nomiss_early", saw_miss, 0);
    tick();
    check("t1_cleared", o_active, 0);
    check("t1_miss", o_miss, 1);
    tick();
    check("t1_miss_once", o_miss, 0);

    // Strum in window hits and retires the note
    spawn_tick(9'd20);
    run(430);
    check("t2_y430", yh(0), 430);
    strum_tick();
    check("t2_hit", o_hit, 1);
    check("t2_noghost", o_ghost, 0);
    check("t2_cleared", o_active, 0);
    tick();
    check("t2_hit_pulse", o_hit, 0);
    clr_flags();
    run(199);
    check("t2_nomiss", saw_miss, 0);

    // Strums just outside the window are ghosts
    do_reset();
    spawn_tick(9'd50);
    run(423);
    check("t3_y423", yh(0), 423);
    strum_tick();
    check("t3_ghost_lo", {o_ghost, o_hit}, 2'b10);
    check("t3_falls", yh(0), 424);
    run(33);
    check("t3_y457", yh(0), 457);
    strum_tick();
    check("t3_ghost_hi", {o_ghost, o_hit}, 2'b10);
    check("t3_still_active", {o_active, yh(0)}, {4'b0001, 10'd458});

    // Fill all slots, overflow, then hit the lowest note and reuse its slot
    do_reset();
    spawn_tick(9'd30); run(19);
    spawn_tick(9'd30); run(19);
    spawn_tick(9'd30); run(19);
    spawn_tick(9'd30);
    check("t4_full", o_active, 4'b1111);
    check("t4_ys", {yh(0), yh(1), yh(2), yh(3)}, {10'd60, 10'd40, 10'd20, 10'd0});
    check("t4_no_ovf_yet", o_overflow, 0);
    spawn_tick(9'd30);
    check("t4_overflow", o_overflow, 1);
    check("t4_full_kept", o_active, 4'b1111);
    run(389);
    check("t4_y450_430", {yh(0), yh(1)}, {10'd450, 10'd430});
    strum_tick();
    check("t4_hit", o_hit, 1);
    check("t4_lowest_gone", o_active, 4'b1110);
    check("t4_slot1_moves", yh(1), 431);
    spawn_tick(9'd30);
    check("t4_reuse", o_active, 4'b1111);
    check("t4_reuse_y", yh(0), 0);
    check("t4_hit_count", o_hit_count, (STATS != 0) ? 1 : 0);

    // Zero height behaves as height 1
    do_reset();
    spawn_tick(9'd0);
    run(10);
    check("t5_ylow10", o_ylow[9:0], 9);
    clr_flags();
    run(471);
    check("t5_y481", {o_active, yh(0)}, {4'b0001, 10'd481});
    check("t5_nomiss_early", saw_miss, 0);
    tick();
    check("t5_miss", {o_miss, o_active}, {1'b1, 4'b0000});

    // Asynchronous reset mid-cycle with three notes in flight
    spawn_tick(9'd40);
    spawn_tick(9'd40);
    spawn_tick(9'd40);
    run(5);
    check("t6_three", o_active, 4'b0111);
    #2;
    in_reset_n = 1'b0;
    #1;
    check("t6_async_clear", o_active, 0);
    check("t6_async_y", o_yhigh, 0);
    tick();
    check("t6_no_pulses", {o_hit, o_ghost, o_miss, o_overflow}, 0);
    in_reset_n = 1'b1;

    // Two notes retire on the same edge in the SPEED=7 lane
    height2 = 9'd8; spawn2 = 1'b1;
    tick();
    height2 = 9'd1;
    tick();
    spawn2 = 1'b0;
    check("t7_both", active2, 2'b11);
    for (int k = 0; k < 68; k++) tick();
    check("t7_y69", yhigh2, {10'd476, 10'd483});
    tick();
    check("t7_y70", {active2, miss2}, {2'b11, 1'b0});
    tick();
    check("t7_double_miss", {active2, miss2}, {2'b00, 1'b1});
    check("t7_miss_count", mc2, (STATS != 0) ? 2 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
